// File: rtl/updown_counter_nbits.sv
// updown_counter_nbits: prescaled up/down counter with load, wrap/saturate end mode and two-digit hex readout
module updown_counter_nbits #(
    parameter int N        = 6,
    parameter int PRESCALE = 1,
    parameter int WRAP     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         done,
    output logic [6:0]   led1,
    output logic [6:0]   led2
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [PW-1:0] pre;
    logic [7:0]    wide;
    logic          tick;
    logic          at_term;

    assign tick    = en && pre == PW'(PRESCALE - 1);
    assign at_term = count == (up ? {N{1'b1}} : {N{1'b0}});
    // zero-extend so the high digit reads 0 for narrow counters
    assign wide    = 8'(count);
    assign led1    = SEG[wide[3:0]];
    assign led2    = SEG[wide[7:4]];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '1;
            pre   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            pre   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (en)
                pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                if (!at_term)
                    count <= up ? count + N'(1) : count - N'(1);
                else if (WRAP != 0) begin
                    count <= ~count;
                    tc    <= 1'b1;
                end else if (!done) begin
                    done <= 1'b1;
                    tc   <= 1'b1;
                end
            end
        end
    end
endmodule
